// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects, load-use stall detection and a shadow EX/MEM/WB pipeline.
module fwd_hazard_unit #(
  parameter int RN_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [RN_W-1:0]  id_rs,
  input  logic [RN_W-1:0]  id_rt,
  input  logic [RN_W-1:0]  id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             stall,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count
);
  logic [RN_W-1:0] ex_rs, ex_rt, ex_rn, mem_rn, wb_rn;
  logic ex_use_rs, ex_use_rt, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, wb_wreg;
  logic haz, kill;
  logic mem_a, mem_b, wb_a, wb_b;
  always_comb begin
    haz = ex_wreg & ex_m2reg & (ex_rn != '0) &
          ((id_use_rs & (id_rs == ex_rn)) | (id_use_rt & (id_rt == ex_rn)));
    stall = haz & ~flush;
    kill = flush | stall;
    // A load in MEM never forwards from r; its data is only usable from WB.
    mem_a = ex_use_rs & mem_wreg & ~mem_m2reg & (mem_rn != '0) & (mem_rn == ex_rs);
    mem_b = ex_use_rt & mem_wreg & ~mem_m2reg & (mem_rn != '0) & (mem_rn == ex_rt);
    wb_a = ex_use_rs & wb_wreg & (wb_rn != '0) & (wb_rn == ex_rs);
    wb_b = ex_use_rt & wb_wreg & (wb_rn != '0) & (wb_rn == ex_rt);
    fwda = mem_a ? 2'b01 : wb_a ? 2'b10 : 2'b00;
    fwdb = mem_b ? 2'b01 : wb_b ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {ex_rs, ex_rt, ex_rn, ex_use_rs, ex_use_rt, ex_wreg, ex_m2reg} <= '0;
      {mem_rn, mem_wreg, mem_m2reg, wb_rn, wb_wreg} <= '0;
      ex_bubble <= 1'b1;
      stall_count <= '0;
    end else begin
      ex_rs <= kill ? '0 : id_rs;
      ex_rt <= kill ? '0 : id_rt;
      ex_rn <= kill ? '0 : id_rn;
      ex_use_rs <= ~kill & id_use_rs;
      ex_use_rt <= ~kill & id_use_rt;
      ex_wreg <= ~kill & id_wreg;
      ex_m2reg <= ~kill & id_m2reg;
      ex_bubble <= kill;
      mem_rn <= ex_rn;
      mem_wreg <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      wb_rn <= mem_rn;
      wb_wreg <= mem_wreg;
      if (stall && ~&stall_count) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: random and directed stimulus scored against an instruction-level pipeline model.
module tb_fwd_hazard_unit;
  localparam int RN_W = 5;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic [RN_W-1:0] rs, rt, rn;
    logic wreg, m2reg, urs, urt;
  } ins_t;
  typedef struct packed {
    logic [1:0] fa, fb;
    logic st, bub;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  logic clk = 0, rst = 1, flush = 0;
  logic [RN_W-1:0] id_rs = 0, id_rt = 0, id_rn = 0;
  logic id_wreg = 0, id_m2reg = 0, id_use_rs = 0, id_use_rt = 0;
  logic [1:0] fwda, fwdb;
  logic stall, ex_bubble;
  logic [CNT_W-1:0] stall_count;
  int total = 0, bad = 0;
  exp_t sb[$];
  ins_t pipe[3];
  logic m_bub;
  int m_cnt;
  bit valid = 0;
  always #5 clk = ~clk;
  fwd_hazard_unit #(.RN_W(RN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .fwda(fwda), .fwdb(fwdb), .stall(stall), .ex_bubble(ex_bubble), .stall_count(stall_count)
  );
  task automatic chk(string n, int a, int r);
    total++;
    if (a != r) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, a, r, $time);
    end
  endtask
  // Newest older instruction writing src decides: ALU result in MEM, otherwise WB data.
  function automatic logic [1:0] fwd(logic [RN_W-1:0] src, logic use_src);
    if (!use_src || src == 0) return 2'b00;
    if (pipe[1].wreg && pipe[1].rn == src && !pipe[1].m2reg) return 2'b01;
    if (pipe[2].wreg && pipe[2].rn == src) return 2'b10;
    return 2'b00;
  endfunction
  task automatic step(input ins_t i, input logic fl, input logic r, output logic st);
    exp_t e;
    logic haz;
    @(negedge clk);
    {id_rs, id_rt, id_rn, id_wreg, id_m2reg, id_use_rs, id_use_rt} = i;
    flush = fl;
    rst = r;
    haz = pipe[0].wreg && pipe[0].m2reg && pipe[0].rn != 0 &&
          ((i.urs && i.rs == pipe[0].rn) || (i.urt && i.rt == pipe[0].rn));
    st = haz && !fl;
    e.fa = fwd(pipe[0].rs, pipe[0].urs);
    e.fb = fwd(pipe[0].rt, pipe[0].urt);
    e.st = st;
    e.bub = m_bub;
    e.cnt = CNT_W'(m_cnt);
    if (valid) sb.push_back(e);
    if (r) begin
      pipe = '{default: '0};
      m_bub = 1;
      m_cnt = 0;
      valid = 1;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (fl || st) ? '0 : i;
      m_bub = fl || st;
      if (st && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("fwda", fwda, e.fa);
      chk("fwdb", fwdb, e.fb);
      chk("stall", stall, e.st);
      chk("ex_bubble", ex_bubble, e.bub);
      chk("stall_count", stall_count, e.cnt);
      chk("load_in_mem_match", int'((dut.mem_wreg && dut.mem_m2reg && dut.mem_rn != 0) &&
          ((dut.ex_use_rs && dut.mem_rn == dut.ex_rs) || (dut.ex_use_rt && dut.mem_rn == dut.ex_rt))), 0);
    end
  end
  function automatic ins_t mk(int rs, int rt, int rn, bit w, bit m, bit urs, bit urt);
    return '{rs: RN_W'(rs), rt: RN_W'(rt), rn: RN_W'(rn), wreg: w, m2reg: m, urs: urs, urt: urt};
  endfunction
  initial begin
    logic st;
    ins_t nop, cur;
    int regs[4] = '{0, 8, 9, 10};
    nop = '0;
    pipe = '{default: '0};
    m_bub = 1;
    m_cnt = 0;
    step(nop, 0, 1, st);
    step(nop, 0, 1, st);
    step(mk(0, 0, 8, 1, 0, 0, 0), 0, 0, st);
    step(mk(8, 0, 1, 1, 0, 1, 0), 0, 0, st);
    repeat (2) step(nop, 0, 0, st);
    step(mk(0, 0, 8, 1, 0, 0, 0), 0, 0, st);
    step(nop, 0, 0, st);
    step(mk(8, 0, 1, 1, 0, 1, 0), 0, 0, st);
    step(mk(0, 0, 8, 1, 0, 0, 0), 0, 0, st);
    step(nop, 0, 0, st);
    step(mk(0, 8, 2, 1, 0, 0, 1), 0, 0, st);
    repeat (2) step(nop, 0, 0, st);
    step(mk(0, 0, 9, 1, 0, 0, 0), 0, 0, st);
    step(mk(0, 0, 9, 1, 0, 0, 0), 0, 0, st);
    step(mk(9, 9, 3, 1, 0, 1, 1), 0, 0, st);
    repeat (2) step(nop, 0, 0, st);
    step(mk(0, 0, 10, 1, 1, 0, 0), 0, 0, st);
    step(mk(0, 10, 4, 1, 0, 0, 1), 0, 0, st);
    step(mk(0, 10, 4, 1, 0, 0, 1), 0, 0, st);
    repeat (3) step(nop, 0, 0, st);
    step(mk(0, 0, 10, 1, 1, 0, 0), 0, 0, st);
    step(mk(0, 10, 4, 1, 0, 0, 1), 1, 0, st);
    repeat (3) step(nop, 0, 0, st);
    step(mk(0, 0, 0, 1, 0, 0, 0), 0, 0, st);
    step(mk(0, 0, 5, 1, 0, 1, 1), 0, 0, st);
    step(mk(0, 0, 0, 1, 1, 0, 0), 0, 0, st);
    step(mk(0, 0, 5, 1, 0, 1, 1), 0, 0, st);
    repeat (3) step(nop, 0, 0, st);
    repeat ((1 << CNT_W) + 3) begin
      step(mk(0, 0, 10, 1, 1, 0, 0), 0, 0, st);
      step(mk(10, 0, 6, 1, 0, 1, 0), 0, 0, st);
      step(mk(10, 0, 6, 1, 0, 1, 0), 0, 0, st);
    end
    step(mk(0, 0, 10, 1, 1, 0, 0), 0, 0, st);
    step(mk(10, 0, 6, 1, 0, 1, 0), 0, 1, st);
    repeat (3) step(nop, 0, 0, st);
    st = 0;
    cur = nop;
    for (int n = 0; n < 400; n++) begin
      if (!st) cur = mk(regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(cur, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0), st);
    end
    @(negedge clk);
    #4;
    chk("queue_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
